// File: rtl/qarb_pkg.sv
// Shared definitions for the queue request arbiter: FSM state encoding and
// request opcode values.
package qarb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic OP_ENQ = 1'b0;
  localparam logic OP_DEQ = 1'b1;

endpackage

// File: rtl/queue_req_arbiter_rr_pick.sv
// Combinational round-robin priority pick: returns the first set request bit
// found searching upward from ptr, wrapping modulo NREQ.
module rr_pick
  import qarb_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int IDW  = 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic            found,
  output logic [IDW-1:0]  idx
);

  // Scan from the farthest candidate back to ptr so the closest match wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req[(int'(ptr) + k) % NREQ]) begin
        found = 1'b1;
        idx   = IDW'((int'(ptr) + k) % NREQ);
      end
    end
  end

endmodule

// File: rtl/queue_req_arbiter.sv
// Round-robin arbiter/sequencer letting NREQ requesters share one FIFO queue.
// One request is granted at a time: IDLE picks, ISSUE strobes the queue (or
// rejects on full/empty), WAIT captures dequeued data, DONE pulses completion.
// Optional build macro QARB_STATS_EN adds saturating stat_ops/stat_rej counters.
module queue_req_arbiter
  import qarb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int WIDTH = 4,
  parameter int IDW   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_op,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_done,
  output logic                  req_err,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy,
  output logic [IDW-1:0]        grant_id,
  output logic                  q_enq,
  output logic                  q_deq,
  output logic [WIDTH-1:0]      q_in,
  input  logic                  q_full,
  input  logic                  q_emp,
  input  logic [WIDTH-1:0]      q_out
`ifdef QARB_STATS_EN
  ,
  output logic [15:0]           stat_ops,
  output logic [15:0]           stat_rej
`endif
);

  state_t           state;
  logic [IDW-1:0]   rr_ptr;
  logic             lat_op;
  logic             pick_found;
  logic [IDW-1:0]   pick_idx;
  logic             sel_op;
  logic [WIDTH-1:0] sel_data;
  logic [NREQ-1:0]  grant_onehot;
  logic             issue_ok;

  rr_pick #(
    .NREQ (NREQ),
    .IDW  (IDW)
  ) u_rr_pick (
    .req   (req_valid),
    .ptr   (rr_ptr),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Select the picked requester's op/data and decode the granted index one-hot.
  always_comb begin
    sel_op       = OP_ENQ;
    sel_data     = '0;
    grant_onehot = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_idx == IDW'(i)) begin
        sel_op   = req_op[i];
        sel_data = req_data[i*WIDTH +: WIDTH];
      end
      if (grant_id == IDW'(i)) begin
        grant_onehot[i] = 1'b1;
      end
    end
  end

  // The queue's full/empty flags are sampled in the ISSUE cycle itself, so the
  // strobes are decoded from the current state rather than registered.
  assign issue_ok = (lat_op == OP_ENQ) ? !q_full : !q_emp;
  assign q_enq    = (state == ISSUE) && (lat_op == OP_ENQ) && !q_full;
  assign q_deq    = (state == ISSUE) && (lat_op == OP_DEQ) && !q_emp;
  assign busy     = (state != IDLE);

  // Request sequencer: grant, issue, optional read wait, completion pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      lat_op   <= OP_ENQ;
      q_in     <= '0;
      rsp_data <= '0;
      req_done <= '0;
      req_err  <= 1'b0;
    end else begin
      req_done <= '0;
      req_err  <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_found) begin
            grant_id <= pick_idx;
            lat_op   <= sel_op;
            q_in     <= sel_data;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if ((lat_op == OP_DEQ) && issue_ok) begin
            state <= WAIT;
          end else begin
            req_done <= grant_onehot;
            req_err  <= !issue_ok;
            state    <= DONE;
          end
        end
        WAIT: begin
          rsp_data <= q_out;
          req_done <= grant_onehot;
          state    <= DONE;
        end
        DONE: begin
          rr_ptr <= (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef QARB_STATS_EN
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Count successful strobes and rejects as each request is issued.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ops <= '0;
      stat_rej <= '0;
    end else if (state == ISSUE) begin
      if (issue_ok) begin
        stat_ops <= sat_inc16(stat_ops);
      end else begin
        stat_rej <= sat_inc16(stat_rej);
      end
    end
  end
`endif

endmodule

// File: tb/tb_queue_req_arbiter.sv
// Randomized bench for queue_req_arbiter with a transaction-level reference
// model (round-robin grant rule plus a FIFO of queue contents) and a simple
// queue controller stand-in driving q_full/q_emp/q_out.
module tb_queue_req_arbiter;

  localparam int NREQ  = 2;
  localparam int WIDTH = 4;
  localparam int IDW   = 1;
  localparam int DEPTH = 4;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_op = '0;
  logic [NREQ*WIDTH-1:0] req_data = '0;
  logic [NREQ-1:0]       req_done;
  logic                  req_err;
  logic [WIDTH-1:0]      rsp_data;
  logic                  busy;
  logic [IDW-1:0]        grant_id;
  logic                  q_enq;
  logic                  q_deq;
  logic [WIDTH-1:0]      q_in;
  logic                  q_full;
  logic                  q_emp;
  logic [WIDTH-1:0]      q_out = '0;
`ifdef QARB_STATS_EN
  logic [15:0]           stat_ops;
  logic [15:0]           stat_rej;
`endif

  queue_req_arbiter #(
    .NREQ  (NREQ),
    .WIDTH (WIDTH),
    .IDW   (IDW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_op    (req_op),
    .req_data  (req_data),
    .req_done  (req_done),
    .req_err   (req_err),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .grant_id  (grant_id),
    .q_enq     (q_enq),
    .q_deq     (q_deq),
    .q_in      (q_in),
    .q_full    (q_full),
    .q_emp     (q_emp),
    .q_out     (q_out)
`ifdef QARB_STATS_EN
    ,
    .stat_ops  (stat_ops),
    .stat_rej  (stat_rej)
`endif
  );

  always #5 clk = ~clk;

  // Queue controller stand-in: q_out valid the cycle after q_deq.
  logic [WIDTH-1:0] env_q[$];
  int env_cnt = 0;
  assign q_full = (env_cnt >= DEPTH);
  assign q_emp  = (env_cnt == 0);

  always @(posedge clk) begin
    if (q_enq) env_q.push_back(q_in);
    if (q_deq && env_q.size() > 0) q_out <= env_q.pop_front();
    env_cnt <= env_q.size();
  end

  // Bench bookkeeping.
  int total = 0;
  int bad = 0;
  int cyc = 0;

  logic             pend[NREQ];
  logic             rop[NREQ];
  logic [WIDTH-1:0] rdat[NREQ];
  bit               rand_mode = 1'b0;
  bit               rst_req = 1'b1;
  bit               just_rst = 1'b1;

  // Reference model state (transaction level).
  logic [WIDTH-1:0] ref_q[$];
  int               m_phase = 0;
  int               m_len = 0;
  int               m_ptr = 0;
  int               m_gid = 0;
  logic             m_op = 1'b0;
  logic             m_err = 1'b0;
  logic [WIDTH-1:0] m_data = '0;
  logic [WIDTH-1:0] m_rsp = '0;
  int               m_ops = 0;
  int               m_rej = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, act, exp);
    end
  endtask

  // One clock: check outputs of the current cycle, drive the requesters for
  // the next edge, then advance the model to the next cycle.
  task automatic step();
    int j;
    @(negedge clk);
    cyc++;

    chk("busy", 32'(busy), 32'(m_phase != 0));
    chk("q_enq", 32'(q_enq), 32'(m_phase == 1 && m_op == 1'b0 && !m_err));
    chk("q_deq", 32'(q_deq), 32'(m_phase == 1 && m_op == 1'b1 && !m_err));
    if (m_phase == 1 && m_op == 1'b0 && !m_err) chk("q_in", 32'(q_in), 32'(m_data));
    chk("grant_id", 32'(grant_id), 32'(m_gid));
    if (m_phase != 0 && m_phase == m_len) begin
      chk("req_done", 32'(req_done), 32'(1) << m_gid);
      chk("req_err", 32'(req_err), 32'(m_err));
      chk("rsp_data", 32'(rsp_data), 32'(m_rsp));
`ifdef QARB_STATS_EN
      chk("stat_ops", 32'(stat_ops), 32'(m_ops));
      chk("stat_rej", 32'(stat_rej), 32'(m_rej));
`endif
    end else begin
      chk("req_done_idle", 32'(req_done), 32'(0));
      if (m_phase == 0) chk("rsp_hold", 32'(rsp_data), 32'(m_rsp));
    end
    if (just_rst) begin
      chk("rst_q_in", 32'(q_in), 32'(0));
      chk("rst_req_err", 32'(req_err), 32'(0));
      chk("rst_rsp_data", 32'(rsp_data), 32'(0));
`ifdef QARB_STATS_EN
      chk("rst_stat_ops", 32'(stat_ops), 32'(0));
      chk("rst_stat_rej", 32'(stat_rej), 32'(0));
`endif
      just_rst = 1'b0;
    end

    for (int i = 0; i < NREQ; i++) begin
      if (req_done[i] === 1'b1) begin
        pend[i] = 1'b0;
      end else if (rand_mode) begin
        if (!pend[i]) begin
          if ($urandom_range(0, 2) == 0) begin
            pend[i] = 1'b1;
            rop[i]  = 1'($urandom_range(0, 1));
            rdat[i] = WIDTH'($urandom);
          end
        end else begin
          rdat[i] = WIDTH'($urandom);
          if ($urandom_range(0, 31) == 0) pend[i] = 1'b0;
        end
      end
      req_valid[i] = pend[i];
      req_op[i]    = rop[i];
      req_data[i*WIDTH +: WIDTH] = rdat[i];
    end
    rst = rst_req;

    if (rst_req) begin
      m_phase = 0; m_len = 0; m_ptr = 0; m_gid = 0;
      m_rsp = '0; m_ops = 0; m_rej = 0; m_err = 1'b0;
      just_rst = 1'b1;
    end else if (m_phase == 0) begin
      for (int k = 0; k < NREQ; k++) begin
        j = (m_ptr + k) % NREQ;
        if (req_valid[j]) begin
          m_gid   = j;
          m_op    = req_op[j];
          m_data  = req_data[j*WIDTH +: WIDTH];
          m_phase = 1;
          m_len   = 2;
          if (m_op == 1'b0) begin
            m_err = (ref_q.size() >= DEPTH);
            if (!m_err) ref_q.push_back(m_data);
          end else begin
            m_err = (ref_q.size() == 0);
            if (!m_err) begin
              m_rsp = ref_q.pop_front();
              m_len = 3;
            end
          end
          if (m_err) m_rej++; else m_ops++;
          break;
        end
      end
    end else if (m_phase == m_len) begin
      m_ptr   = (m_gid + 1) % NREQ;
      m_phase = 0;
    end else begin
      m_phase++;
    end
  endtask

  task automatic run_one(input int i, input logic op, input logic [WIDTH-1:0] d);
    pend[i] = 1'b1;
    rop[i]  = op;
    rdat[i] = d;
    repeat (6) step();
  endtask

  initial begin
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 1'b0;
      rop[i]  = 1'b0;
      rdat[i] = '0;
    end

    rst_req = 1'b1;
    repeat (3) step();
    rst_req = 1'b0;

    // Enqueue / dequeue basics, then empty and full rejects.
    run_one(0, 1'b0, 4'hA);
    run_one(1, 1'b1, 4'h0);
    run_one(0, 1'b0, 4'h5);
    run_one(1, 1'b1, 4'h0);
    run_one(1, 1'b1, 4'h0);
    for (int n = 0; n < DEPTH; n++) run_one(n % NREQ, 1'b0, WIDTH'(n + 1));
    run_one(1, 1'b0, 4'hF);

    // Both requesters held continuously: grants must alternate.
    pend[0] = 1'b1; rop[0] = 1'b1; rdat[0] = '0;
    pend[1] = 1'b1; rop[1] = 1'b1; rdat[1] = '0;
    repeat (3) step();
    pend[0] = 1'b1; pend[1] = 1'b1;
    repeat (8) step();

    // Reset while a dequeue sits in WAIT.
    run_one(0, 1'b0, 4'h3);
    pend[1] = 1'b1; rop[1] = 1'b1; rdat[1] = '0;
    for (int n = 0; n < 8; n++) begin
      step();
      if (m_phase == 2 && m_len == 3) break;
    end
    rst_req = 1'b1;
    pend[0] = 1'b1; rop[0] = 1'b0; rdat[0] = 4'h7;
    step();
    rst_req = 1'b0;
    repeat (10) step();

    // Randomized traffic with data scrambled after grant and occasional aborts.
    rand_mode = 1'b1;
    repeat (3000) step();
    rand_mode = 1'b0;
    repeat (12) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
